inst_loader: RTL and testbench

- Boot-time instruction loader upstream of the core's instruction cache write port (wren/wraddr/wrdata, currently tied off).
- Receives a framed byte stream from the UART receiver, assembles little-endian 32-bit words and writes them to consecutive instruction-cache word addresses.
- Holds the core in reset until a complete, valid image has been written.

---
 rtl/inst_loader.sv | 169 ++++++++++++++++
 tb/tb_inst_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a MAGIC/length-framed UART byte stream into
// 32-bit words for the I-cache write port. INST_LOADER_CHKSUM_EN adds a trailing XOR check byte.
module inst_loader #(
    parameter int         ADDR_W = 10,
    parameter int         DEPTH  = 1 << ADDR_W,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_vld,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddr,
    output logic [31:0]       wrdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef INST_LOADER_CHKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W:0]     wl_q, wl_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [31:0]         wrdata_q, wrdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                core_rst_q, core_rst_d;
    logic [15:0]         len_full;
    logic [31:0]         word_shift;
    logic                last_word;
`ifdef INST_LOADER_CHKSUM_EN
    logic [7:0]          xor_q, xor_d;
    state_t              after_data;
    assign after_data = S_CHK;
`else
    state_t              after_data;
    assign after_data = S_DONE;
`endif

    assign len_full   = {rx_data, len_q[7:0]};
    // Bytes enter at the top and shift down, so the first byte of a word lands in [7:0].
    assign word_shift = {rx_data, word_q[31:8]};
    assign last_word  = (32'(wl_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        wl_d     = wl_q;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
`ifdef INST_LOADER_CHKSUM_EN
        xor_d    = xor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_vld && rx_data == MAGIC) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_vld) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_vld) begin
                    len_d = len_full;
                    cnt_d = 2'd0;
`ifdef INST_LOADER_CHKSUM_EN
                    xor_d = 8'h00;
`endif
                    if (32'(len_full) > DEPTH) state_d = S_ERR;
                    else if (len_full == 16'd0) state_d = after_data;
                    else state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_vld) begin
                    word_d = word_shift;
                    cnt_d  = cnt_q + 2'd1;
`ifdef INST_LOADER_CHKSUM_EN
                    xor_d  = xor_q ^ rx_data;
`endif
                    if (cnt_q == 2'd3) begin
                        wren_d   = 1'b1;
                        wraddr_d = wl_q[ADDR_W-1:0];
                        wrdata_d = word_shift;
                        wl_d     = wl_q + 1'b1;
                        if (last_word) state_d = after_data;
                    end
                end
            end
`ifdef INST_LOADER_CHKSUM_EN
            S_CHK: begin
                if (rx_vld) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Holding done back during the final write keeps core_rst high past the last wren.
        done_d     = done_q | ((state_d == S_DONE) && !wren_d);
        err_d      = err_q | (state_d == S_ERR);
        core_rst_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            wl_q       <= '0;
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
`ifdef INST_LOADER_CHKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wl_q       <= wl_d;
            wren_q     <= wren_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
`ifdef INST_LOADER_CHKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign wren         = wren_q;
    assign wraddr       = wraddr_q;
    assign wrdata       = wrdata_q;
    assign words_loaded = wl_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign core_rst     = core_rst_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: frames are parsed by a queue-based reference model
// and the captured write pulses and final status are compared against it.
module tb_inst_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef INST_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_vld = 1'b0;
    logic              wren;
    logic [ADDR_W-1:0] wraddr;
    logic [31:0]       wrdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .core_rst(core_rst),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frame[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int          exp_words;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W:0]   got_wl[$];
    logic              got_crst[$];

    always @(negedge clk) begin
        if (wren) begin
            got_addr.push_back(wraddr);
            got_data.push_back(wrdata);
            got_wl.push_back(words_loaded);
            got_crst.push_back(core_rst);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: find the frame, then apply the length/payload/checksum rules directly.
    task automatic model();
        int i, n, p;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i + 2 >= frame.size()) return;
        n = int'(frame[i+1]) | (int'(frame[i+2]) << 8);
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        p = i + 3;
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w % DEPTH);
            exp_data.push_back({frame[p+3], frame[p+2], frame[p+1], frame[p]});
            x = x ^ frame[p] ^ frame[p+1] ^ frame[p+2] ^ frame[p+3];
            p += 4;
        end
        exp_words = n;
        if (!CHK_EN) exp_done = 1'b1;
        else if (frame[p] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    function automatic logic [7:0] payload_xor(int start, int nbytes);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < nbytes; k++) x ^= frame[start+k];
        return x;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk);
        #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[k]) begin
            send_byte(frame[k]);
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wren"}, 64'(wren), 64'd0);
        check({tag, "_wraddr"}, 64'(wraddr), 64'd0);
        check({tag, "_wrdata"}, 64'(wrdata), 64'd0);
        check({tag, "_wl"}, 64'(words_loaded), 64'd0);
        check({tag, "_crst"}, 64'(core_rst), 64'd1);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"}, 64'(load_err), 64'd0);
    endtask

    task automatic check_results(input string tag, input int base);
        int n;
        n = got_addr.size() - base;
        check({tag, "_nwr"}, 64'(n), 64'(exp_addr.size()));
        for (int k = 0; k < n && k < exp_addr.size(); k++) begin
            check({tag, "_addr"}, 64'(got_addr[base+k]), 64'(exp_addr[k]));
            check({tag, "_data"}, 64'(got_data[base+k]), 64'(exp_data[k]));
            check({tag, "_wlwr"}, 64'(got_wl[base+k]), 64'(k + 1));
            check({tag, "_crstwr"}, 64'(got_crst[base+k]), 64'd1);
        end
        check({tag, "_done"}, 64'(load_done), 64'(exp_done));
        check({tag, "_err"}, 64'(load_err), 64'(exp_err));
        check({tag, "_crst"}, 64'(core_rst), 64'(!exp_done));
        check({tag, "_wl"}, 64'(words_loaded), 64'(exp_words));
    endtask

    task automatic nominal_frame();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int base, n, g;
        logic [7:0] chk;

        idle(2);
        do_reset();
        check_reset("reset");

        // Nominal load with done-latency checks.
        nominal_frame();
        base = got_addr.size();
        send_frame(1'b0);
        chk = payload_xor(3, 8);
`ifdef INST_LOADER_CHKSUM_EN
        send_byte(chk);
        check("nom_done_lat", 64'(load_done), 64'd1);
`else
        check("nom_crst_lastwr", 64'(core_rst), 64'd1);
        idle(1);
        check("nom_done_lat", 64'(load_done), 64'd1);
`endif
        frame.push_back(chk);
        idle(3);
        model();
        check_results("nominal", base);

        // Bad checksum.
        do_reset();
        nominal_frame();
        frame.push_back(8'h81);
        base = got_addr.size();
        send_frame(1'b0);
        idle(3);
        model();
        check_results("badchk", base);

        // Oversize length, error visible right after LEN_HI.
        do_reset();
        base = got_addr.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        check("over_err_lat", 64'(load_err), 64'd1);
        frame = '{8'hA5, 8'h01, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00};
        for (int k = 3; k < frame.size(); k++) send_byte(frame[k]);
        idle(3);
        model();
        check_results("oversize", base);

        // Leading garbage and random gaps.
        do_reset();
        nominal_frame();
        frame.push_back(payload_xor(3, 8));
        frame.push_front(8'h5A);
        frame.push_front(8'hFF);
        frame.push_front(8'h00);
        base = got_addr.size();
        send_frame(1'b1);
        idle(3);
        model();
        check_results("garbage", base);

        // Reset mid-frame, with rx_vld carrying MAGIC in the reset cycle.
        do_reset();
        nominal_frame();
        base = got_addr.size();
        for (int k = 0; k < 9; k++) send_byte(frame[k]);
        check("mid_wl_before", 64'(words_loaded), 64'd1);
        rst = 1'b1;
        rx_data = 8'hA5;
        rx_vld = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_vld = 1'b0;
        check_reset("mid_rst");
        frame.push_back(payload_xor(3, 8));
        base = got_addr.size();
        send_frame(1'b0);
        idle(3);
        model();
        check_results("midreset", base);

        // Empty image.
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        base = got_addr.size();
        send_frame(1'b0);
        idle(3);
        model();
        check_results("empty", base);

        // Full-depth image: the last address and the widest word count.
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h04};
        for (int k = 0; k < 4 * DEPTH; k++) frame.push_back(8'($urandom));
        frame.push_back(payload_xor(3, 4 * DEPTH));
        base = got_addr.size();
        send_frame(1'b0);
        idle(3);
        model();
        check_results("full", base);

        // Random frames.
        for (int t = 0; t < 40; t++) begin
            do_reset();
            frame.delete();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                g = int'($urandom_range(0, 255));
                if (g == 'hA5) g = 0;
                frame.push_back(8'(g));
            end
            frame.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) begin
                frame.push_back(8'($urandom_range(1, 255)));
                frame.push_back(8'($urandom_range(4, 255)));
            end else begin
                n = int'($urandom_range(0, 6));
                frame.push_back(8'(n));
                frame.push_back(8'h00);
                g = frame.size();
                for (int k = 0; k < 4 * n; k++) frame.push_back(8'($urandom));
                chk = payload_xor(g, 4 * n);
                if ($urandom_range(0, 3) == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
                frame.push_back(chk);
            end
            frame.push_back(8'($urandom));
            frame.push_back(8'($urandom));
            base = got_addr.size();
            send_frame($urandom_range(0, 1) == 1);
            idle(3);
            model();
            check_results("rand", base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
